// File: rtl/pipe2_pkg.sv
// rtl/pipe2_pkg.sv - shared types and defaults for the two-stage flow-controlled pipeline
package pipe2_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    // Occupancy state; the value equals the number of valid stages.
    // 2'd3 is not a member and is recovered to OCC_EMPTY.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe2_stage.sv
// rtl/pipe2_stage.sv - one valid+data pipeline register with load enable and clear
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture d/d_valid this edge
//   clear         synchronous drop of the valid bit (wins over load)
//   d, d_valid    incoming word and its valid bit
//   q, q_valid    registered word and its valid bit
module pipe2_stage
    import pipe2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Data loads whenever enabled, regardless of valid; only the valid bit
    // is affected by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (load) begin
                q <= d;
            end
            if (clear) begin
                q_valid <= 1'b0;
            end else if (load) begin
                q_valid <= d_valid;
            end
        end
    end

endmodule

// File: rtl/pipe2_ctrl.sv
// rtl/pipe2_ctrl.sv - flow-controlled two-stage register pipeline a -> b -> c
//
// Optional feature macro: PIPE2_STALL_CNT_EN (adds stall_cnt output).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   a, a_valid         producer word and valid
//   a_ready            pipeline accepts a this cycle (combinational)
//   b, b_valid         stage-1 register and valid
//   c, c_valid         stage-2 register (output) and valid
//   c_ready            consumer takes c this cycle
//   flush              synchronous discard of all in-flight words
//   occ                occupancy state (0 empty, 1 one word, 2 full)
//   out_cnt            words delivered on c, wrapping
//   stall_cnt          cycles with c_valid & ~c_ready, saturating (optional)
module pipe2_ctrl
    import pipe2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] b,
    output logic             b_valid,
    output logic [WIDTH-1:0] c,
    output logic             c_valid,
    input  logic             c_ready,
    input  logic             flush,
    output logic [1:0]       occ,
`ifdef PIPE2_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [CNT_W-1:0] out_cnt
);

    logic adv_c;
    logic in_fire;
    logic out_fire;
    occ_t occ_q;
    occ_t occ_d;

    // Stage 2 may load whenever it is empty or being drained; this also
    // collapses a bubble into c while the consumer stalls.
    assign adv_c    = ~c_valid | c_ready;
    assign a_ready  = ~b_valid | adv_c;
    assign in_fire  = a_valid & a_ready;
    assign out_fire = c_valid & c_ready;

    pipe2_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (a_ready),
        .clear   (flush),
        .d       (a),
        .d_valid (a_valid),
        .q       (b),
        .q_valid (b_valid)
    );

    pipe2_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (adv_c),
        .clear   (flush),
        .d       (b),
        .d_valid (b_valid),
        .q       (c),
        .q_valid (c_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // From ONE, any accept without a delivery leaves two words in flight:
    // either c holds one and b takes the new word, or b's word collapses
    // into c while the new word enters b.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) occ_d = OCC_ONE;
                end
                OCC_ONE: begin
                    if (out_fire && !in_fire)      occ_d = OCC_EMPTY;
                    else if (in_fire && !out_fire) occ_d = OCC_FULL;
                    else                           occ_d = OCC_ONE;
                end
                OCC_FULL: begin
                    if (out_fire && !in_fire) occ_d = OCC_ONE;
                    else                      occ_d = OCC_FULL;
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    assign occ = occ_q;

    // A delivery in the flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (out_fire) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE2_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (c_valid && !c_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe2_ctrl.sv
// tb/tb_pipe2_ctrl.sv - directed self-checking bench for pipe2_ctrl
module tb_pipe2_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] b;
    logic       b_valid;
    logic [3:0] c;
    logic       c_valid;
    logic       c_ready;
    logic       flush;
    logic [1:0] occ;
    logic [7:0] out_cnt;
`ifdef PIPE2_STALL_CNT_EN
    logic [7:0] stall_cnt;
`endif

    int n_total;
    int n_pass;

    pipe2_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b         (b),
        .b_valid   (b_valid),
        .c         (c),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .flush     (flush),
        .occ       (occ),
`ifdef PIPE2_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy must track the valid bits at every sampled cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("occ_inv", 32'(occ), 32'(b_valid) + 32'(c_valid));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a       = 4'h0;
        a_valid = 1'b0;
        c_ready = 1'b0;
        flush   = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] vec [5];
        n_total = 0;
        n_pass  = 0;
        vec[0] = 4'h3; vec[1] = 4'h7; vec[2] = 4'hf; vec[3] = 4'ha; vec[4] = 4'h2;

        rst_n = 1'b0; a = 4'h0; a_valid = 1'b0; c_ready = 1'b0; flush = 1'b0;
        #3;
        check("rst_b", 32'(b), 32'h0);
        check("rst_c", 32'(c), 32'h0);
        check("rst_valids", 32'({b_valid, c_valid}), 32'h0);
        check("rst_occ", 32'(occ), 32'h0);
        check("rst_cnt", 32'(out_cnt), 32'h0);
        do_reset();

        // Back-to-back stream, c appears two edges after the first accept
        c_ready = 1'b1;
        a_valid = 1'b1;
        a = vec[0];
        step();
        check("strm_b0", 32'(b), 32'h3);
        check("strm_cv0", 32'(c_valid), 32'h0);
        for (int i = 1; i < 6; i++) begin
            if (i < 5) a = vec[i];
            else       a_valid = 1'b0;
            step();
            check($sformatf("strm_c%0d", i - 1), 32'(c), 32'(vec[i-1]));
            check($sformatf("strm_cv%0d", i - 1), 32'(c_valid), 32'h1);
        end
        step();
        check("strm_empty", 32'(c_valid), 32'h0);
        check("strm_cnt", 32'(out_cnt), 32'd5);

        // Stall with two words held
        c_ready = 1'b0;
        a_valid = 1'b1;
        a = 4'h3;
        step();
        a = 4'h7;
        step();
        a_valid = 1'b0;
        check("stall_occ", 32'(occ), 32'd2);
        check("stall_ardy", 32'(a_ready), 32'h0);
        step();
        step();
        check("stall_c", 32'(c), 32'h3);
        check("stall_b", 32'(b), 32'h7);
        check("stall_occ2", 32'(occ), 32'd2);
        c_ready = 1'b1;
        #1;
        check("drain_ardy", 32'(a_ready), 32'h1);
        step();
        check("drain_c7", 32'(c), 32'h7);
        check("drain_cv", 32'(c_valid), 32'h1);
        step();
        check("drain_empty", 32'(c_valid), 32'h0);
        check("drain_cnt", 32'(out_cnt), 32'd7);

        // Single word collapses into c under stall
        c_ready = 1'b0;
        a_valid = 1'b1;
        a = 4'hf;
        step();
        a_valid = 1'b0;
        step();
        check("coll_c", 32'(c), 32'hf);
        check("coll_valids", 32'({b_valid, c_valid}), 32'h1);
        check("coll_occ", 32'(occ), 32'd1);
        check("coll_ardy", 32'(a_ready), 32'h1);
        c_ready = 1'b1;
        step();
        check("coll_cnt", 32'(out_cnt), 32'd8);
        check("coll_occ0", 32'(occ), 32'd0);

        // Flush a full pipeline while a word is offered and c is taken
        c_ready = 1'b0;
        a_valid = 1'b1;
        a = 4'h3;
        step();
        a = 4'h7;
        step();
        check("fl_full", 32'(occ), 32'd2);
        flush   = 1'b1;
        c_ready = 1'b1;
        a = 4'ha;
        #1;
        check("fl_ardy", 32'(a_ready), 32'h1);
        step();
        flush   = 1'b0;
        a_valid = 1'b0;
        check("fl_occ", 32'(occ), 32'd0);
        check("fl_valids", 32'({b_valid, c_valid}), 32'h0);
        check("fl_cnt", 32'(out_cnt), 32'd9);
        step();
        step();
        check("fl_nodeliver", 32'(c_valid), 32'h0);
        check("fl_cnt2", 32'(out_cnt), 32'd9);

        // Asynchronous reset mid-stream
        c_ready = 1'b1;
        a_valid = 1'b1;
        a = 4'h5;
        step();
        a = 4'h6;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_b", 32'(b), 32'h0);
        check("ar_c", 32'(c), 32'h0);
        check("ar_valids", 32'({b_valid, c_valid}), 32'h0);
        check("ar_occ", 32'(occ), 32'h0);
        check("ar_cnt", 32'(out_cnt), 32'h0);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_valid = 1'b1;
        a = 4'h9;
        step();
        a_valid = 1'b0;
        step();
        check("ar_first", 32'(c), 32'h9);
        check("ar_firstv", 32'(c_valid), 32'h1);
        step();
        check("ar_cnt1", 32'(out_cnt), 32'd1);

        // 256 deliveries wrap the 8-bit counter
        do_reset();
        c_ready = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i);
            step();
        end
        a_valid = 1'b0;
        step();
        check("wrap_255", 32'(out_cnt), 32'd255);
        step();
        check("wrap_0", 32'(out_cnt), 32'd0);
        check("wrap_empty", 32'(c_valid), 32'h0);

`ifdef PIPE2_STALL_CNT_EN
        do_reset();
        a_valid = 1'b1;
        a = 4'h1;
        step();
        a_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        check("stall_cnt5", 32'(stall_cnt), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_cnt_fl", 32'(stall_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
